// File: rtl/midori_mask_pkg.sv
// Shared constants, lane slicing helpers and the component-function evaluator
// for the three-share masked Midori F layer.
package midori_mask_pkg;

   localparam int SHARES      = 3;
   localparam int NIBBLE_W    = 4;
   localparam int R_PER_LANE  = 18;
   localparam int RS_PER_LANE = 6;
   localparam int CF_PER_LANE = 27;
   localparam int MAX_LANES   = 16;

   localparam int NIB_BUS_W = NIBBLE_W * MAX_LANES;
   localparam int R_BUS_W   = R_PER_LANE * MAX_LANES;
   localparam int RS_BUS_W  = RS_PER_LANE * MAX_LANES;

   typedef logic [SHARES-1:0][NIBBLE_W-1:0] shares_t;

   function automatic logic [NIBBLE_W-1:0] nib_slice(input logic [NIB_BUS_W-1:0] bus, input int k);
      return NIBBLE_W'(bus >> (NIBBLE_W * k));
   endfunction

   function automatic logic [R_PER_LANE-1:0] r_slice(input logic [R_BUS_W-1:0] bus, input int k);
      return R_PER_LANE'(bus >> (R_PER_LANE * k));
   endfunction

   function automatic logic [RS_PER_LANE-1:0] rs_slice(input logic [RS_BUS_W-1:0] bus, input int k);
      return RS_PER_LANE'(bus >> (RS_PER_LANE * k));
   endfunction

   // Component m = 9*group + 3*share + term. Each output bit is a ^ (b & c);
   // share j owns the cross products b_j & c_{j+term}, and every refresh bit
   // is added to exactly two components so it cancels after compression.
   function automatic logic cf_f(input int m, input shares_t sh,
                                 input logic [R_PER_LANE-1:0] r,
                                 input logic [RS_PER_LANE-1:0] rs);
      int         grp, shr, term;
      logic [1:0] j, q, nxt, a_i, b_i, c_i;
      logic [2:0] rp_i, rq_i, ra, rb;
      logic [5:0] rg;
      logic       v;
      grp  = m / 9;
      shr  = (m % 9) / 3;
      term = m % 3;
      j    = 2'(shr);
      q    = 2'((shr + term) % 3);
      nxt  = 2'((shr + 1) % 3);
      case (grp)
         0:       begin a_i = 2'd1; b_i = 2'd2; c_i = 2'd3; end
         1:       begin a_i = 2'd2; b_i = 2'd0; c_i = 2'd3; end
         default: begin a_i = 2'd3; b_i = 2'd0; c_i = 2'd1; end
      endcase
      rg   = 6'(r >> (6 * grp));
      ra   = rg[2:0];
      rb   = rg[5:3];
      rp_i = 3'(2 * grp);
      rq_i = 3'(2 * grp + 1);
      v = sh[j][b_i] & sh[q][c_i];
      case (term)
         0:       v = v ^ sh[j][a_i] ^ ra[j] ^ rb[j];
         1:       v = v ^ ra[nxt];
         default: v = v ^ rb[nxt];
      endcase
      if (term == 2 && shr != 0)
         v = v ^ rs[rp_i];
      if ((term == 2 && shr == 0) || (term == 1 && shr == 2))
         v = v ^ rs[rq_i];
      return v;
   endfunction

endpackage

// File: rtl/masked_f_lane.sv
// One nibble lane: 27 registered component functions, bit-0 share capture and
// XOR compression. MSBOX_OUTREG_EN adds a registered output stage.
module masked_f_lane
   import midori_mask_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
`ifdef MSBOX_OUTREG_EN
   input  logic                   load2,
`endif
   input  logic [NIBBLE_W-1:0]    x1,
   input  logic [NIBBLE_W-1:0]    x2,
   input  logic [NIBBLE_W-1:0]    x3,
   input  logic [R_PER_LANE-1:0]  r,
   input  logic [RS_PER_LANE-1:0] rs,
   output logic [NIBBLE_W-1:0]    y1,
   output logic [NIBBLE_W-1:0]    y2,
   output logic [NIBBLE_W-1:0]    y3
);

   shares_t                xs;
   logic [CF_PER_LANE-1:0] cf_next;
   logic [CF_PER_LANE-1:0] cf_reg;
   logic [SHARES-1:0]      areg;
   logic [8:0]             cmp;
   shares_t                comp;

   assign xs = {x3, x2, x1};

   for (genvar gi = 0; gi < CF_PER_LANE; gi++) begin : g_cf
      assign cf_next[gi] = cf_f(gi, xs, r, rs);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cf_reg <= '0;
         areg   <= '0;
      end else if (load) begin
         cf_reg <= cf_next;
         areg   <= {x3[0], x2[0], x1[0]};
      end
   end

   // cmp[3*share + group]; groups 0/1/2 drive output bits 0/1/3
   for (genvar gi = 0; gi < 3; gi++) begin : g_grp
      for (genvar gj = 0; gj < SHARES; gj++) begin : g_shr
         assign cmp[3*gj + gi] = ^cf_reg[9*gi + 3*gj +: 3];
      end
   end

   // Bit 2 is a share-rotated copy of input bit 0
   assign comp[0] = {cmp[2], areg[1], cmp[1], cmp[0]};
   assign comp[1] = {cmp[5], areg[2], cmp[4], cmp[3]};
   assign comp[2] = {cmp[8], areg[0], cmp[7], cmp[6]};

`ifdef MSBOX_OUTREG_EN
   shares_t out_reg;

   always_ff @(posedge clk) begin
      if (rst)
         out_reg <= '0;
      else if (load2)
         out_reg <= comp;
   end

   assign y1 = out_reg[0];
   assign y2 = out_reg[1];
   assign y3 = out_reg[2];
`else
   assign y1 = comp[0];
   assign y2 = comp[1];
   assign y3 = comp[2];
`endif

endmodule

// File: rtl/masked_f_layer.sv
// Elastic three-share masked F layer over NSBOX lanes; randomness is consumed
// only on accepted transfers. MSBOX_OUTREG_EN selects a two-stage pipeline.
module masked_f_layer
   import midori_mask_pkg::*;
#(
   parameter int NSBOX = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [4*NSBOX-1:0]       in1,
   input  logic [4*NSBOX-1:0]       in2,
   input  logic [4*NSBOX-1:0]       in3,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [18*NSBOX-1:0]      r,
   input  logic [6*NSBOX-1:0]       rs,
   input  logic                     rnd_valid,
   output logic                     rnd_ready,
   output logic [4*NSBOX-1:0]       out1,
   output logic [4*NSBOX-1:0]       out2,
   output logic [4*NSBOX-1:0]       out3,
   output logic                     out_valid,
   input  logic                     out_ready
);

   logic [NIB_BUS_W-1:0] in1_pad, in2_pad, in3_pad;
   logic [R_BUS_W-1:0]   r_pad;
   logic [RS_BUS_W-1:0]  rs_pad;
   logic                 v_reg, v_next, accept;

   assign in1_pad = NIB_BUS_W'(in1);
   assign in2_pad = NIB_BUS_W'(in2);
   assign in3_pad = NIB_BUS_W'(in3);
   assign r_pad   = R_BUS_W'(r);
   assign rs_pad  = RS_BUS_W'(rs);

   assign accept    = in_valid & rnd_valid & in_ready;
   assign rnd_ready = accept;

`ifdef MSBOX_OUTREG_EN
   logic v2_reg, v2_next, load2;

   assign in_ready  = ~v_reg | ~v2_reg | out_ready;
   assign load2     = v_reg & (~v2_reg | out_ready);
   assign out_valid = v2_reg;

   always_comb begin
      v_next  = v_reg;
      v2_next = v2_reg;
      if (out_ready)
         v2_next = 1'b0;
      if (load2) begin
         v2_next = 1'b1;
         v_next  = 1'b0;
      end
      if (accept)
         v_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_reg  <= 1'b0;
         v2_reg <= 1'b0;
      end else begin
         v_reg  <= v_next;
         v2_reg <= v2_next;
      end
   end
`else
   assign in_ready  = ~v_reg | out_ready;
   assign out_valid = v_reg;

   always_comb begin
      v_next = v_reg;
      if (out_ready)
         v_next = 1'b0;
      if (accept)
         v_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         v_reg <= 1'b0;
      else
         v_reg <= v_next;
   end
`endif

   for (genvar gi = 0; gi < NSBOX; gi++) begin : g_lane
      masked_f_lane u_lane (
         .clk   (clk),
         .rst   (rst),
         .load  (accept),
`ifdef MSBOX_OUTREG_EN
         .load2 (load2),
`endif
         .x1    (nib_slice(in1_pad, gi)),
         .x2    (nib_slice(in2_pad, gi)),
         .x3    (nib_slice(in3_pad, gi)),
         .r     (r_slice(r_pad, gi)),
         .rs    (rs_slice(rs_pad, gi)),
         .y1    (out1[NIBBLE_W*gi +: NIBBLE_W]),
         .y2    (out2[NIBBLE_W*gi +: NIBBLE_W]),
         .y3    (out3[NIBBLE_W*gi +: NIBBLE_W])
      );
   end

endmodule

// File: tb/tb_masked_f_layer.sv
// Directed bench for masked_f_layer: unmasked reference model plus queue
// scoreboard checked every cycle, and hand-computed literal expectations.
module tb_masked_f_layer;

   localparam int N  = 16;
   localparam int W  = 4 * N;
   localparam int RW = 18 * N;
   localparam int SW = 6 * N;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  in1 = '0, in2 = '0, in3 = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [RW-1:0] r = '0;
   logic [SW-1:0] rs = '0;
   logic          rnd_valid = 1'b0;
   logic          rnd_ready;
   logic [W-1:0]  out1, out2, out3;
   logic          out_valid;
   logic          out_ready = 1'b1;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   bit mon_en = 1'b0;

   masked_f_layer #(.NSBOX(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .r         (r),
      .rs        (rs),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

`ifdef MSBOX_OUTREG_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   function automatic logic [3:0] f_ref(input logic [3:0] x);
      return {x[3] ^ (x[0] & x[1]), x[0], x[2] ^ (x[0] & x[3]), x[1] ^ (x[2] & x[3])};
   endfunction

   function automatic logic [W-1:0] f_vec(input logic [W-1:0] x);
      logic [W-1:0] y;
      for (int k = 0; k < N; k++) y[4*k +: 4] = f_ref(x[4*k +: 4]);
      return y;
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      for (int k = 0; k < W/32; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [RW-1:0] rand_r();
      logic [RW-1:0] v;
      for (int k = 0; k < RW/32; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [SW-1:0] rand_s();
      logic [SW-1:0] v;
      for (int k = 0; k < SW/32; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   // Scoreboard: occupancy-based handshake expectations and unmasked data
   always @(negedge clk) begin
      logic exp_ir;
      if (mon_en) begin
         exp_ir = (exp_q.size() < DEPTH) || out_ready;
         check1("in_ready", in_ready, exp_ir);
         check1("rnd_ready", rnd_ready, in_valid & rnd_valid & exp_ir);
`ifndef MSBOX_OUTREG_EN
         check1("out_valid", out_valid, exp_q.size() > 0);
`endif
         if (out_valid && exp_q.size() > 0)
            check("data", out1 ^ out2 ^ out3, exp_q[0]);
         if (rst) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready && exp_q.size() > 0)
               void'(exp_q.pop_front());
            if (in_valid && rnd_valid && exp_ir)
               exp_q.push_back(f_vec(in1 ^ in2 ^ in3));
         end
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] s1, input logic [W-1:0] s2,
                       input logic [RW-1:0] rv, input logic [SW-1:0] sv);
      logic ok;
      @(posedge clk); #1;
      in1 = s1; in2 = s2; in3 = x ^ s1 ^ s2;
      r = rv; rs = sv;
      in_valid = 1'b1; rnd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check1("send_accept", ok, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; rnd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] x, o, s1, s2, hold1, hold2, hold3;
      logic [RW-1:0] rv;
      logic [SW-1:0] sv;
      logic [3*W-1:0] sh_a, sh_b;

      // reset then idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out1", out1, '0);
      check("rst_out2", out2, '0);
      check("rst_out3", out3, '0);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_in_ready", in_ready, 1'b1);
      check1("rst_rnd_ready", rnd_ready, 1'b0);
      mon_en = 1'b1;

      // functional sweep: lane k carries k
      for (int k = 0; k < N; k++) x[4*k +: 4] = 4'(k);
      send(x, rand_w(), rand_w(), rand_r(), rand_s());
      @(negedge clk);
      check1("sweep_valid", out_valid, 1'b1);
      o = out1 ^ out2 ^ out3;
      check("lane0", W'(o[3:0]), W'(4'h0));
      check("lane1", W'(o[7:4]), W'(4'h4));
      check("lane3", W'(o[15:12]), W'(4'hD));
      check("laneA", W'(o[43:40]), W'(4'h9));
      check("laneF", W'(o[63:60]), W'(4'h4));
      check1("lane1_bit2", o[6], 1'b1);

      // back-to-back random transfers at full throughput
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         x = rand_w(); s1 = rand_w(); s2 = rand_w();
         in1 = s1; in2 = s2; in3 = x ^ s1 ^ s2;
         r = rand_r(); rs = rand_s();
         in_valid = 1'b1; rnd_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rnd_valid = 1'b0;
      repeat (2) @(posedge clk);

      // randomness independence: same input and sharing, one r bit differs
      x = {N{4'hA}}; s1 = rand_w(); s2 = rand_w(); rv = rand_r(); sv = rand_s();
      send(x, s1, s2, rv, sv);
      @(negedge clk);
      sh_a = {out1, out2, out3};
      check("indep_a", out1 ^ out2 ^ out3, {N{4'h9}});
      send(x, s1, s2, rv ^ RW'(1), sv);
      @(negedge clk);
      sh_b = {out1, out2, out3};
      check("indep_b", out1 ^ out2 ^ out3, {N{4'h9}});
      check1("indep_shares_differ", sh_a !== sh_b, 1'b1);

      // randomness starvation
      @(posedge clk); #1;
      x = rand_w(); s1 = rand_w(); s2 = rand_w();
      in1 = s1; in2 = s2; in3 = x ^ s1 ^ s2; r = rand_r(); rs = rand_s();
      in_valid = 1'b1; rnd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check1("starve_rnd_ready", rnd_ready, 1'b0);
         check1("starve_out_valid", out_valid, 1'b0);
      end
      @(posedge clk); #1 rnd_valid = 1'b1;
      @(negedge clk);
      check1("starve_accept", rnd_ready, 1'b1);
      @(posedge clk); #1 in_valid = 1'b0; rnd_valid = 1'b0;
      @(negedge clk);
      check1("starve_out_valid_after", out_valid, 1'b1);
      check("starve_data", out1 ^ out2 ^ out3, f_vec(x));

      // back-pressure
      @(posedge clk); #1 out_ready = 1'b0;
      send(rand_w(), rand_w(), rand_w(), rand_r(), rand_s());
      @(negedge clk);
      check1("bp_valid", out_valid, 1'b1);
      hold1 = out1; hold2 = out2; hold3 = out3;
      @(posedge clk); #1;
      x = rand_w(); s1 = rand_w(); s2 = rand_w();
      in1 = s1; in2 = s2; in3 = x ^ s1 ^ s2; r = rand_r(); rs = rand_s();
      in_valid = 1'b1; rnd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check1("bp_in_ready", in_ready, 1'b0);
         check1("bp_rnd_ready", rnd_ready, 1'b0);
         check("bp_hold1", out1, hold1);
         check("bp_hold2", out2, hold2);
         check("bp_hold3", out3, hold3);
         if (i < 3) @(posedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      check1("bp_drain_accept", rnd_ready, 1'b1);
      @(posedge clk); #1 in_valid = 1'b0; rnd_valid = 1'b0;
      @(negedge clk);
      check1("bp_new_valid", out_valid, 1'b1);
      check("bp_new_data", out1 ^ out2 ^ out3, f_vec(x));

      // reset mid-stall
      @(posedge clk); #1 out_ready = 1'b0;
      send(rand_w(), rand_w(), rand_w(), rand_r(), rand_s());
      @(negedge clk);
      check1("rs_valid_before", out_valid, 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check1("rs_out_valid", out_valid, 1'b0);
      check("rs_out", out1 | out2 | out3, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check1("rs_no_transfer", out_valid, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/masked_f_layer.md
# masked_f_layer

Parametrised second-order (three-share) masked Midori F-function layer that processes NSBOX nibbles per transfer through the existing 27-component-function / compression structure, with elastic valid/ready flow control and randomness gating. It sits between the masked G layer and the linear layer of the round datapath. It replaces per-nibble free-running F instances with one back-pressure-aware stage that consumes fresh randomness only on accepted transfers.

## Interface
- NSBOX, default 16: number of 4-bit lanes; legal range 1..16.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in1, in2, in3  input  4*NSBOX  shares 0/1/2; lane k occupies bits [4k+3:4k].
- in_valid  input  1  input shares valid.
- in_ready  output  1  stage can accept this cycle.
- r  input  18*NSBOX  refresh randomness; lane k uses [18k+17:18k], split into r1/r2/r3 at 6 bits each, low to high.
- rs  input  6*NSBOX  extra refresh randomness; lane k uses [6k+5:6k].
- rnd_valid  input  1  r/rs fresh this cycle.
- rnd_ready  output  1  r/rs consumed this cycle; the PRNG must advance.
- out1, out2, out3  output  4*NSBOX  result shares 0/1/2.
- out_valid  output  1  result shares valid.
- out_ready  input  1  downstream accepts.

## Operation
- accept = in_valid & rnd_valid & in_ready; rnd_ready = accept. in_ready does not depend on in_valid or rnd_valid.
- On accept, each lane loads its 27 component-function outputs into the CF register and captures its three bit-0 input shares in areg.
- Output per lane is formed combinationally from registers:
  - Output bits 0, 1, 3: 3-input XOR compression of CF register groups. Group i, share j = CF[9i+3j .. 9i+3j+2]; bits 0/1/3 map to groups 0/1/2.
  - Output bit 2: share-rotated passthrough, out1 = areg[1], out2 = areg[2], out3 = areg[0]. Unmasked, this equals input bit 0.
- Stage state: valid flag V.
  - V sets on accept.
  - V clears on out_valid & out_ready without a simultaneous accept.
  - Simultaneous drain and accept keeps V = 1 and loads new data.
- in_ready = ~V | out_ready (full-throughput pipeline).
- Stall (V = 1, out_ready = 0): CF register, areg and out* hold bit-exact; no randomness is consumed.
- Bubble (no accept): registers hold their previous contents. They are never reloaded from un-accepted inputs, so no share recombination occurs across transfers.
- rnd_valid = 0 with in_valid = 1: no accept; the input must stay stable (source-held, standard valid/ready).
- Mid-operation rst: V and all registers clear on the next edge; any in-flight result is discarded.

## Timing
- Reset values: out1/out2/out3 = 0, out_valid = 0, CF register = 0, areg = 0. in_ready = 1 and rnd_ready = 0 in the cycle after reset.
- Latency: accept at edge n gives out_valid = 1 after edge n, so the result is visible in cycle n+1.
- Throughput: one transfer per cycle when out_ready = 1 and rnd_valid = 1.
- With MSBOX_OUTREG_EN: latency is 2 cycles; see Configuration.

## Configuration
- MSBOX_OUTREG_EN defined:
  - Adds a second registered stage holding compressed out1/out2/out3 with its own valid flag V2. Removes the XOR tree from the output path.
  - Stage-1 ready = ~V | ~V2 | out_ready (two-stage skid-free elastic pipeline).
  - Latency is 2 cycles; the outputs, V and V2 reset to 0.
- Undefined: single stage as in Operation; latency 1.

## Structure
- Package midori_mask_pkg holds:
  - SHARES = 3, NIBBLE_W = 4.
  - R_PER_LANE = 18, RS_PER_LANE = 6, CF_PER_LANE = 27.
  - Lane slicing functions for the in*/r/rs buses.
- Sub-module masked_f_lane: one lane containing the 27 CF_F instances, CF register with load enable, areg, and compression. It is generated NSBOX times.
- Top-level masked_f_layer owns only the V/V2 flags, handshake logic and bus slicing.

## Test plan
- Reset then idle: hold rst = 1 for 2 cycles, release with in_valid = 0 → out* = 0, out_valid = 0, in_ready = 1, rnd_ready = 0.
- Functional sweep:
  - Stimulus: NSBOX = 16; lane k's unmasked input = k, randomly shared; random r/rs; rnd_valid = 1, out_ready = 1.
  - Response:
    - One cycle later, out1^out2^out3 per lane equals the unmasked F reference model for the values 0..F.
    - Unmasked bit 2 equals input bit 0, e.g. input 0x1 → bit 2 = 1.
- Randomness independence: same unmasked input 0xA sent twice with different r/rs → identical unmasked outputs and differing share values.
- Randomness starvation: in_valid = 1, rnd_valid = 0 for 3 cycles → rnd_ready = 0, out_valid stays 0. Raising rnd_valid gives accept and out_valid one cycle later.
- Back-pressure: out_ready = 0 for 4 cycles while out_valid = 1 → out* held bit-exact, in_ready = 0, rnd_ready = 0. Raising out_ready with in_valid = 1 drains and accepts in the same cycle.
- Reset mid-stall: assert rst while V = 1, out_ready = 0 → next cycle out_valid = 0, out* = 0; no transfer is issued afterwards.
